gb_serial: RTL and testbench

- Memory-mapped responder for the Game Boy serial link port: SB at FF01 (data) and SC at FF02 (control).
- Answers the CPU's load/store bus and returns read data with the same 2-cycle latency as the other bus responders. Read data feeds the top-level indata mux, gated by rhit.
- Shifts SB out MSB-first on sout while shifting sin in. The bit clock is either generated internally or taken from an external sclk_in.
- Raises a one-cycle interrupt request when a transfer completes.

---
 rtl/gb_io_pkg.sv | 22 ++
 rtl/sync_edge.sv | 45 ++++
 rtl/gb_serial.sv | 212 +++++++++++++++++++++
 tb/tb_gb_serial.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gb_io_pkg
// Description : Shared addresses, SC bit indices and serial-port state type.
// Revision    : 1.0 - initial release
// ============================================================================
package gb_io_pkg;

    localparam logic [15:0] SB_ADDR_DEFAULT = 16'hff01;
    localparam logic [15:0] SC_ADDR_DEFAULT = 16'hff02;

    localparam int SC_START = 7;
    localparam int SC_CS    = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER_INT = 2'd1,
        XFER_EXT = 2'd2
    } state_t;

endpackage : gb_io_pkg
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Two-flop synchroniser for an asynchronous input with a
//               one-cycle rising-edge pulse on the synchronised signal.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d_in,
    output logic sync_out,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Reset to the line's idle level so leaving reset never fakes an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;

endmodule : sync_edge
`default_nettype wire

// File: rtl/gb_serial.sv
`default_nettype none
// ============================================================================
// Module      : gb_serial
// Description : Game Boy link-port responder (SB/SC) with 2-cycle read
//               latency, internal or external bit clock and completion irq.
// Revision    : 1.0 - initial release
// ============================================================================
module gb_serial
    import gb_io_pkg::*;
#(
    parameter int          BIT_CYCLES = 512,
    parameter logic [15:0] SB_ADDR    = SB_ADDR_DEFAULT,
    parameter logic [15:0] SC_ADDR    = SC_ADDR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        load,
    input  logic        store,
    output logic [7:0]  rdata,
    output logic        rhit,
    output logic        sout,
    input  logic        sin,
    output logic        sclk_out,
    input  logic        sclk_in,
    output logic        irq
);

    localparam int            PH_W    = $clog2(BIT_CYCLES);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(BIT_CYCLES / 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(BIT_CYCLES - 1);

    generate
        if ((BIT_CYCLES < 4) || ((BIT_CYCLES % 2) != 0)) begin : g_bad_bit_cycles
            $error("gb_serial: BIT_CYCLES must be even and at least 4");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [7:0]      sb_q, sb_d;
    logic            start_q, start_d;
    logic            cs_q, cs_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            pend_q, pend_d;
    logic            irq_q, irq_d;
    logic            rd1_hit_q, rd1_hit_d;
    logic [7:0]      rd1_data_q, rd1_data_d;
    logic            rhit_q, rhit_d;
    logic [7:0]      rdata_q, rdata_d;

    logic            sin_sync, sin_rise;
    logic            sclk_sync, sclk_rise;
    logic            unused_sync;
    logic            shift_now;
    logic            rd_hit;
    logic [7:0]      rd_val;

    sync_edge #(.RESET_VAL(1'b0)) u_sin_sync (
        .clock    (clock),
        .reset    (reset),
        .d_in     (sin),
        .sync_out (sin_sync),
        .rise     (sin_rise)
    );

    sync_edge #(.RESET_VAL(1'b1)) u_sclk_sync (
        .clock    (clock),
        .reset    (reset),
        .d_in     (sclk_in),
        .sync_out (sclk_sync),
        .rise     (sclk_rise)
    );

    assign unused_sync = sin_rise ^ sclk_sync;

    // Transfer engine and register writes; stores are applied last so they win.
    always_comb begin
        state_d   = state_q;
        sb_d      = sb_q;
        start_d   = start_q;
        cs_d      = cs_q;
        bitcnt_d  = bitcnt_q;
        phase_d   = phase_q;
        pend_d    = pend_q;
        irq_d     = 1'b0;
        shift_now = 1'b0;

        case (state_q)
            XFER_INT: begin
                if (!pend_q) begin
                    phase_d = phase_q + PH_ONE;
                    if (phase_q == PH_HALF) begin
                        shift_now = 1'b1;
                    end
                    if (phase_q == PH_LAST) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        phase_d  = '0;
                        if (bitcnt_q == 3'd7) begin
                            // Hold phase so sclk_out stays high through the done cycle.
                            pend_d  = 1'b1;
                            phase_d = phase_q;
                        end
                    end
                end
            end
            XFER_EXT: begin
                if (!pend_q && sclk_rise) begin
                    shift_now = 1'b1;
                    bitcnt_d  = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (shift_now) begin
            sb_d = {sb_q[6:0], sin_sync};
        end

        if (pend_q) begin
            state_d  = IDLE;
            start_d  = 1'b0;
            pend_d   = 1'b0;
            irq_d    = 1'b1;
            bitcnt_d = '0;
            phase_d  = '0;
        end

        if (store && (addr == SB_ADDR) && (state_q == IDLE)) begin
            sb_d = wdata;
        end

        if (store && (addr == SC_ADDR)) begin
            cs_d    = wdata[SC_CS];
            start_d = wdata[SC_START];
            if (wdata[SC_START]) begin
                // A start landing in the done cycle begins a fresh transfer.
                if ((state_q == IDLE) || pend_q) begin
                    state_d  = wdata[SC_CS] ? XFER_INT : XFER_EXT;
                    bitcnt_d = '0;
                    phase_d  = '0;
                    pend_d   = 1'b0;
                end
            end else if ((state_q != IDLE) && !pend_q) begin
                state_d  = IDLE;
                bitcnt_d = '0;
                phase_d  = '0;
                pend_d   = 1'b0;
            end
        end
    end

    // Read pipeline: capture on load, present one cycle later.
    always_comb begin
        rd_hit = (addr == SB_ADDR) || (addr == SC_ADDR);
        if (addr == SC_ADDR) begin
            rd_val = {start_q, 6'b111111, cs_q};
        end else if (addr == SB_ADDR) begin
            rd_val = sb_q;
        end else begin
            rd_val = 8'h00;
        end

        rd1_hit_d  = load & rd_hit;
        rd1_data_d = (load && rd_hit) ? rd_val : 8'h00;
        rhit_d     = rd1_hit_q;
        rdata_d    = rd1_hit_q ? rd1_data_q : 8'h00;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            sb_q       <= 8'h00;
            start_q    <= 1'b0;
            cs_q       <= 1'b0;
            bitcnt_q   <= '0;
            phase_q    <= '0;
            pend_q     <= 1'b0;
            irq_q      <= 1'b0;
            rd1_hit_q  <= 1'b0;
            rd1_data_q <= 8'h00;
            rhit_q     <= 1'b0;
            rdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            sb_q       <= sb_d;
            start_q    <= start_d;
            cs_q       <= cs_d;
            bitcnt_q   <= bitcnt_d;
            phase_q    <= phase_d;
            pend_q     <= pend_d;
            irq_q      <= irq_d;
            rd1_hit_q  <= rd1_hit_d;
            rd1_data_q <= rd1_data_d;
            rhit_q     <= rhit_d;
            rdata_q    <= rdata_d;
        end
    end

    assign sout     = sb_q[7];
    assign sclk_out = ~((state_q == XFER_INT) && !pend_q && (phase_q < PH_HALF));
    assign irq      = irq_q;
    assign rdata    = rdata_q;
    assign rhit     = rhit_q;

endmodule : gb_serial
`default_nettype wire

// File: tb/tb_gb_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_gb_serial
// Description : Scoreboard bench for gb_serial with a bit-level serial model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_serial;

    localparam logic [15:0] SB = 16'hff01;
    localparam logic [15:0] SC = 16'hff02;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr  = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        load  = 1'b0;
    logic        store = 1'b0;
    logic [7:0]  rdata;
    logic        rhit;
    logic        sout;
    logic        sin_drv  = 1'b0;
    logic        loopback = 1'b0;
    logic        sclk_out;
    logic        sclk_in  = 1'b1;
    logic        irq;
    wire         sin = loopback ? sout : sin_drv;

    typedef struct {
        int         due;
        logic       hit;
        logic [7:0] data;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   irq_count = 0;
    int   irq_cyc   = 0;
    bit   done      = 1'b0;

    gb_serial #(
        .BIT_CYCLES (8),
        .SB_ADDR    (SB),
        .SC_ADDR    (SC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .load     (load),
        .store    (store),
        .rdata    (rdata),
        .rhit     (rhit),
        .sout     (sout),
        .sin      (sin),
        .sclk_out (sclk_out),
        .sclk_in  (sclk_in),
        .irq      (irq)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pops the scoreboard when a read is due and counts irq pulses.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (irq) begin
                irq_count++;
                irq_cyc = cyc;
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                checks++;
                if (rhit !== e.hit || rdata !== e.data) begin
                    errors++;
                    $display("FAIL read %s: rhit=%b rdata=%02h, expected rhit=%b rdata=%02h",
                             e.name, rhit, rdata, e.hit, e.data);
                end
            end else if (!reset && rhit !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rhit: rhit=%b rdata=%02h, expected rhit=0", rhit, rdata);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_store(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        store = 1'b1;
        tick(1);
        store = 1'b0;
    endtask

    task automatic bus_load(input string name, input logic [15:0] a,
                            input logic hit, input logic [7:0] data);
        exp_t e;
        e.due  = cyc + 2;
        e.hit  = hit;
        e.data = data;
        e.name = name;
        sbq.push_back(e);
        addr = a;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(2);
    endtask

    // Waits for one more irq than base; an expired budget counts as a failure.
    task automatic wait_irq(input string name, input int base, input int budget);
        int n = 0;
        while (irq_count == base && n < budget) begin
            tick(1);
            n++;
        end
        tick(3);
        check({name, "_irq_count"}, irq_count, base + 1);
    endtask

    task automatic wait_sclk(input logic level, input int budget);
        int n = 0;
        while (sclk_out !== level && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    task automatic ext_pulse();
        sclk_in = 1'b0;
        tick(4);
        sclk_in = 1'b1;
        tick(4);
    endtask

    initial begin : stim
        logic [7:0] model;
        logic [7:0] pattern;
        logic       b;
        int         base;
        int         t0;

        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        check("reset_sclk_out", sclk_out, 1);
        check("reset_irq", irq, 0);
        check("reset_sout", sout, 0);
        bus_load("reset_sc", SC, 1'b1, 8'h7e);
        bus_load("reset_sb", SB, 1'b1, 8'h00);
        bus_load("miss_c000", 16'hc000, 1'b0, 8'h00);

        // Internal transfer, sin=0: sout walks SB MSB-first, zeros shift in
        sin_drv = 1'b0;
        base    = irq_count;
        pattern = 8'ha5;
        model   = pattern;
        bus_store(SB, pattern);
        bus_store(SC, 8'h81);
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            wait_sclk(1'b0, 20);
            check($sformatf("int_sout_bit%0d", i), sout, model[7]);
            model = {model[6:0], 1'b0};
            wait_sclk(1'b1, 20);
        end
        wait_irq("int", base, 40);
        check("int_irq_latency_ok", (irq_cyc - t0 >= 60) && (irq_cyc - t0 <= 70), 1);
        bus_load("int_sb", SB, 1'b1, model);
        bus_load("int_sc", SC, 1'b1, 8'h7f);

        // Loopback: 8 rotations restore the original byte
        loopback = 1'b1;
        base     = irq_count;
        bus_store(SB, 8'h3c);
        bus_store(SC, 8'h81);
        bus_load("loop_sc_active", SC, 1'b1, 8'hff);
        wait_irq("loop", base, 120);
        bus_load("loop_sb", SB, 1'b1, 8'h3c);
        loopback = 1'b0;

        // External clock: stalls without edges, then fills with ones
        sin_drv = 1'b1;
        base    = irq_count;
        bus_store(SB, 8'h00);
        bus_store(SC, 8'h80);
        tick(1000);
        check("ext_stall_irq", irq_count, base);
        check("ext_stall_sclk_out", sclk_out, 1);
        bus_load("ext_stall_sb", SB, 1'b1, 8'h00);
        bus_load("ext_stall_sc", SC, 1'b1, 8'hfe);
        for (int i = 0; i < 8; i++) ext_pulse();
        wait_irq("ext", base, 20);
        bus_load("ext_sb", SB, 1'b1, 8'hff);
        bus_load("ext_sc", SC, 1'b1, 8'h7e);

        // Randomised external transfers against the shift model
        for (int r = 0; r < 4; r++) begin
            model = 8'($urandom);
            base  = irq_count;
            bus_store(SB, model);
            bus_store(SC, 8'h80);
            for (int i = 0; i < 8; i++) begin
                b       = 1'($urandom_range(0, 1));
                sin_drv = b;
                tick(3);
                check($sformatf("rnd%0d_sout_bit%0d", r, i), sout, model[7]);
                ext_pulse();
                model = {model[6:0], b};
            end
            wait_irq($sformatf("rnd%0d", r), base, 20);
            bus_load($sformatf("rnd%0d_sb", r), SB, 1'b1, model);
        end

        // Abort after three bits
        sin_drv = 1'b0;
        base    = irq_count;
        bus_store(SB, 8'hf0);
        bus_store(SC, 8'h81);
        tick(26);
        bus_store(SC, 8'h01);
        check("abort_sclk_out", sclk_out, 1);
        tick(100);
        check("abort_no_irq", irq_count, base);
        bus_load("abort_sc", SC, 1'b1, 8'h7f);
        bus_store(SB, 8'h99);
        bus_load("abort_sb_store", SB, 1'b1, 8'h99);

        // Store to SB while active is ignored
        sin_drv = 1'b1;
        base    = irq_count;
        bus_store(SB, 8'hc3);
        bus_store(SC, 8'h81);
        tick(10);
        bus_store(SB, 8'h55);
        wait_irq("sbwr", base, 120);
        bus_load("sbwr_sb", SB, 1'b1, 8'hff);

        for (int n = 0; n < 20 && sbq.size() > 0; n++) tick(1);
        check("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gb_serial
`default_nettype wire
